// File: rtl/line_memory_controller_pkg.sv
// Shared types and line geometry for the line memory controller.
// Optional statistics are enabled with LINE_MEMORY_CONTROLLER_STATS_EN.
package line_memory_controller_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      EVICT = 2'd2
   } memc_state_e;

   localparam int LINE_WORDS_DEF = 64;
   localparam int SRAM_AW        = 10;
   localparam int EXT_AW         = 30;
   localparam int DATA_W         = 32;

   // Word idx of the line holding base, wrapping inside the line.
   function automatic logic [EXT_AW-1:0] line_addr(
      input logic [EXT_AW-1:0]  base,
      input logic [SRAM_AW-1:0] idx,
      input int                 lw_log
   );
      logic [EXT_AW-1:0] mask;
      mask = (EXT_AW'(1) << lw_log) - EXT_AW'(1);
      return (base & ~mask) | ((base + EXT_AW'(idx)) & mask);
   endfunction

endpackage

// File: rtl/line_memory_controller_if.sv
// External memory request/response channel of the line memory controller.
// Requests use valid/ready; read responses return in order.
interface line_memory_controller_if;
   import line_memory_controller_pkg::*;

   logic              OUT_EXT_valid;
   logic              OUT_EXT_we;
   logic [EXT_AW-1:0] OUT_EXT_addr;
   logic [DATA_W-1:0] OUT_EXT_data;
   logic              IN_EXT_ready;
   logic              IN_EXT_rvalid;
   logic [DATA_W-1:0] IN_EXT_rdata;

   modport master (
      output OUT_EXT_valid,
      output OUT_EXT_we,
      output OUT_EXT_addr,
      output OUT_EXT_data,
      input  IN_EXT_ready,
      input  IN_EXT_rvalid,
      input  IN_EXT_rdata
   );

   modport slave (
      input  OUT_EXT_valid,
      input  OUT_EXT_we,
      input  OUT_EXT_addr,
      input  OUT_EXT_data,
      output IN_EXT_ready,
      output IN_EXT_rvalid,
      output IN_EXT_rdata
   );

endinterface

// File: rtl/line_memory_controller_wfifo.sv
// Eviction data FIFO between the SRAM read port and the external write channel.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module memc_wfifo
   import line_memory_controller_pkg::*;
#(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = DATA_W,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      do_pop  = pop && (cnt_q != '0);
      do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      if (do_push) begin
         mem_d[wr_q] = data;
         wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) begin
         rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign head  = mem_q[rd_q];
   assign empty = (cnt_q == '0);
   assign count = cnt_q;

endmodule

// File: rtl/line_memory_controller.sv
// Whole-line fill/evict engine between cache SRAM and external memory.
// LINE_MEMORY_CONTROLLER_STATS_EN enables fill/evict/busy-cycle counters.
module line_memory_controller
   import line_memory_controller_pkg::*;
#(
   parameter  int NUM_CACHES  = 2,
   parameter  int LINE_WORDS  = LINE_WORDS_DEF,
   parameter  int WFIFO_DEPTH = 4,
   localparam int ID_W        = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CACHES-1:0]         IN_ce,
   input  logic [NUM_CACHES-1:0]         IN_we,
   input  logic [NUM_CACHES*SRAM_AW-1:0] IN_sramAddr,
   input  logic [NUM_CACHES*EXT_AW-1:0]  IN_extAddr,
   output logic [SRAM_AW-1:0]            OUT_progress,
   output logic [ID_W-1:0]               OUT_cacheID,
   output logic                          OUT_busy,
   output logic                          OUT_CACHE_ce,
   output logic                          OUT_CACHE_we,
   output logic [SRAM_AW-1:0]            OUT_CACHE_addr,
   output logic [DATA_W-1:0]             OUT_CACHE_data,
   input  logic [DATA_W-1:0]             IN_CACHE_data,
   line_memory_controller_if.master      ext,
   output logic [31:0]                   OUT_statFills,
   output logic [31:0]                   OUT_statEvicts,
   output logic [31:0]                   OUT_statBusyCycles
);

   localparam int LW_LOG = $clog2(LINE_WORDS);
   localparam int IW     = LW_LOG + 1;
   localparam int FCW    = $clog2(WFIFO_DEPTH + 1);

   memc_state_e        state_q, state_d;
   logic               busy_q, busy_d;
   logic [SRAM_AW-1:0] prog_q, prog_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [SRAM_AW-1:0] sbase_q, sbase_d;
   logic [EXT_AW-1:0]  ebase_q, ebase_d;
   logic [IW-1:0]      iss_q, iss_d;
   logic               rd_fly_q, rd_fly_d;

   logic [ID_W-1:0]    win;
   logic               accept;
   logic               last_beat;
   logic               f_push;
   logic               f_pop;
   logic [DATA_W-1:0]  f_head;
   logic               f_empty;
   logic [FCW-1:0]     f_count;

   // Lowest-index requester wins; the rest are dropped.
   always_comb begin
      win = '0;
      for (int i = NUM_CACHES - 1; i >= 0; i--) begin
         if (IN_ce[i]) begin
            win = ID_W'(i);
         end
      end
   end

   assign accept    = (state_q == IDLE) && (|IN_ce);
   assign last_beat = (prog_q == SRAM_AW'(LINE_WORDS - 1));

   always_comb begin
      state_d            = state_q;
      busy_d             = busy_q;
      prog_d             = prog_q;
      id_d               = id_q;
      sbase_d            = sbase_q;
      ebase_d            = ebase_q;
      iss_d              = iss_q;
      rd_fly_d           = 1'b0;
      f_push             = 1'b0;
      f_pop              = 1'b0;
      OUT_CACHE_ce       = 1'b0;
      OUT_CACHE_we       = 1'b0;
      OUT_CACHE_addr     = '0;
      OUT_CACHE_data     = '0;
      ext.OUT_EXT_valid  = 1'b0;
      ext.OUT_EXT_we     = 1'b0;
      ext.OUT_EXT_addr   = '0;
      ext.OUT_EXT_data   = '0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               id_d    = win;
               busy_d  = 1'b1;
               prog_d  = '0;
               iss_d   = '0;
               sbase_d = IN_sramAddr[int'(win)*SRAM_AW +: SRAM_AW];
               ebase_d = IN_extAddr[int'(win)*EXT_AW +: EXT_AW];
               state_d = IN_we[win] ? EVICT : FILL;
            end
         end
         FILL: begin
            ext.OUT_EXT_valid = (iss_q != IW'(LINE_WORDS));
            ext.OUT_EXT_addr  = line_addr(ebase_q, SRAM_AW'(iss_q), LW_LOG);
            if (ext.OUT_EXT_valid && ext.IN_EXT_ready) begin
               iss_d = iss_q + 1'b1;
            end
            if (ext.IN_EXT_rvalid) begin
               OUT_CACHE_ce   = 1'b1;
               OUT_CACHE_we   = 1'b1;
               OUT_CACHE_addr = SRAM_AW'(line_addr(EXT_AW'(sbase_q), prog_q, LW_LOG));
               OUT_CACHE_data = ext.IN_EXT_rdata;
               prog_d         = prog_q + 1'b1;
               if (last_beat) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         EVICT: begin
            f_push = rd_fly_q;
            // Reserve a FIFO slot for every read still in flight.
            if ((iss_q != IW'(LINE_WORDS)) &&
                ((32'(f_count) + 32'(rd_fly_q)) < 32'(WFIFO_DEPTH))) begin
               OUT_CACHE_ce   = 1'b1;
               OUT_CACHE_addr = SRAM_AW'(line_addr(EXT_AW'(sbase_q), SRAM_AW'(iss_q), LW_LOG));
               iss_d          = iss_q + 1'b1;
               rd_fly_d       = 1'b1;
            end
            ext.OUT_EXT_valid = !f_empty;
            ext.OUT_EXT_we    = !f_empty;
            if (!f_empty) begin
               ext.OUT_EXT_addr = line_addr(ebase_q, prog_q, LW_LOG);
               ext.OUT_EXT_data = f_head;
            end
            if (!f_empty && ext.IN_EXT_ready) begin
               f_pop  = 1'b1;
               prog_d = prog_q + 1'b1;
               if (last_beat) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         prog_q   <= '0;
         id_q     <= '0;
         sbase_q  <= '0;
         ebase_q  <= '0;
         iss_q    <= '0;
         rd_fly_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         prog_q   <= prog_d;
         id_q     <= id_d;
         sbase_q  <= sbase_d;
         ebase_q  <= ebase_d;
         iss_q    <= iss_d;
         rd_fly_q <= rd_fly_d;
      end
   end

   memc_wfifo #(
      .DEPTH (WFIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_wfifo (
      .clk   (clk),
      .rst   (rst),
      .push  (f_push),
      .data  (IN_CACHE_data),
      .pop   (f_pop),
      .head  (f_head),
      .empty (f_empty),
      .count (f_count)
   );

   assign OUT_progress = prog_q;
   assign OUT_cacheID  = id_q;
   assign OUT_busy     = busy_q;

`ifdef LINE_MEMORY_CONTROLLER_STATS_EN
   logic [31:0] fills_q, fills_d;
   logic [31:0] evicts_q, evicts_d;
   logic [31:0] bcyc_q, bcyc_d;

   always_comb begin
      fills_d  = fills_q;
      evicts_d = evicts_q;
      bcyc_d   = busy_q ? bcyc_q + 32'd1 : bcyc_q;
      if (accept) begin
         if (IN_we[win]) begin
            evicts_d = evicts_q + 32'd1;
         end else begin
            fills_d = fills_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fills_q  <= '0;
         evicts_q <= '0;
         bcyc_q   <= '0;
      end else begin
         fills_q  <= fills_d;
         evicts_q <= evicts_d;
         bcyc_q   <= bcyc_d;
      end
   end

   assign OUT_statFills      = fills_q;
   assign OUT_statEvicts     = evicts_q;
   assign OUT_statBusyCycles = bcyc_q;
`else
   assign OUT_statFills      = '0;
   assign OUT_statEvicts     = '0;
   assign OUT_statBusyCycles = '0;
`endif

endmodule

// File: tb/tb_line_memory_controller.sv
// Scoreboard bench for line_memory_controller: fills, evicts, arbitration,
// wrap, mid-transfer reset and (with LINE_MEMORY_CONTROLLER_STATS_EN) stats.
module tb_line_memory_controller;
   import line_memory_controller_pkg::*;

   localparam int NC  = 2;
   localparam int LW  = 64;
   localparam int DEP = 4;

   typedef struct packed {
      logic [29:0] addr;
      logic        we;
      logic [31:0] data;
   } ext_exp_t;

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] data;
   } sw_exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NC-1:0] in_ce = '0;
   logic [NC-1:0] in_we = '0;
   logic [19:0]   in_sram = '0;
   logic [59:0]   in_ext = '0;
   logic [9:0]    prog;
   logic [0:0]    cid;
   logic          busy;
   logic          c_ce;
   logic          c_we;
   logic [9:0]    c_addr;
   logic [31:0]   c_wdata;
   logic [31:0]   c_rdata;
   logic [31:0]   st_f;
   logic [31:0]   st_e;
   logic [31:0]   st_b;

   line_memory_controller_if ext_if ();

   line_memory_controller #(
      .NUM_CACHES  (NC),
      .LINE_WORDS  (LW),
      .WFIFO_DEPTH (DEP)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .IN_ce              (in_ce),
      .IN_we              (in_we),
      .IN_sramAddr        (in_sram),
      .IN_extAddr         (in_ext),
      .OUT_progress       (prog),
      .OUT_cacheID        (cid),
      .OUT_busy           (busy),
      .OUT_CACHE_ce       (c_ce),
      .OUT_CACHE_we       (c_we),
      .OUT_CACHE_addr     (c_addr),
      .OUT_CACHE_data     (c_wdata),
      .IN_CACHE_data      (c_rdata),
      .ext                (ext_if.master),
      .OUT_statFills      (st_f),
      .OUT_statEvicts     (st_e),
      .OUT_statBusyCycles (st_b)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // SRAM model: one-cycle read latency, eviction image preloaded on request.
   logic [31:0] sram [1024];
   logic [31:0] sram_rd = '0;
   bit          preload = 1'b0;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < LW; i++) begin
            sram[10'h3C0 + i] <= 32'hA000 + 32'(i);
         end
      end
      if (c_ce && c_we) sram[c_addr] <= c_wdata;
      if (c_ce && !c_we) sram_rd <= sram[c_addr];
   end

   assign c_rdata = sram_rd;

   ext_exp_t    ext_q  [$];
   sw_exp_t     sw_q   [$];
   logic [31:0] resp_q [$];

   int cyc      = 0;
   int rdy_mode = 0;
   bit mon_on   = 1'b1;
   bit active   = 1'b0;
   int exp_prog = 0;
   int rd_seq   = 0;
   int exp_busy = 0;
   int sram_rds = 0;
   int beats    = 0;
   int max_out  = 0;

   // External memory: ready pattern per mode, in-order read responses.
   initial begin
      ext_if.IN_EXT_ready  = 1'b0;
      ext_if.IN_EXT_rvalid = 1'b0;
      ext_if.IN_EXT_rdata  = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rdy_mode == 2) ext_if.IN_EXT_ready = 1'b1;
         else if (rdy_mode == 1) ext_if.IN_EXT_ready = (cyc % 3 == 0);
         else ext_if.IN_EXT_ready = ($urandom_range(0, 2) != 0);
         if (resp_q.size() > 0 && (rdy_mode == 2 || $urandom_range(0, 1) == 1)) begin
            ext_if.IN_EXT_rvalid = 1'b1;
            ext_if.IN_EXT_rdata  = resp_q.pop_front();
         end else begin
            ext_if.IN_EXT_rvalid = 1'b0;
            ext_if.IN_EXT_rdata  = '0;
         end
      end
   end

   always @(negedge clk) begin : mon
      ext_exp_t e;
      sw_exp_t  s;
      if (mon_on) begin
         if (active) begin
            check("progress", 64'(prog), 64'(exp_prog));
            if (exp_prog == LW) begin
               check("busy_drop", 64'(busy), 64'(0));
               active = 1'b0;
            end else begin
               check("busy", 64'(busy), 64'(1));
               exp_busy++;
            end
         end
         if (ext_if.OUT_EXT_valid && ext_if.IN_EXT_ready) begin
            check("ext_expected", 64'(ext_q.size() > 0), 64'(1));
            if (ext_q.size() > 0) begin
               e = ext_q.pop_front();
               check("ext_addr", 64'(ext_if.OUT_EXT_addr), 64'(e.addr));
               check("ext_we", 64'(ext_if.OUT_EXT_we), 64'(e.we));
               if (e.we) begin
                  check("ext_data", 64'(ext_if.OUT_EXT_data), 64'(e.data));
                  exp_prog++;
                  beats++;
               end else begin
                  resp_q.push_back(32'(rd_seq));
                  rd_seq++;
               end
            end
         end
         if (c_ce && c_we) begin
            check("sram_expected", 64'(sw_q.size() > 0), 64'(1));
            if (sw_q.size() > 0) begin
               s = sw_q.pop_front();
               check("sram_addr", 64'(c_addr), 64'(s.addr));
               check("sram_data", 64'(c_wdata), 64'(s.data));
               exp_prog++;
            end
         end
         if (c_ce && !c_we) sram_rds++;
         if (sram_rds - beats > max_out) max_out = sram_rds - beats;
      end
   end

   task automatic launch(input logic [NC-1:0] ce, input logic [NC-1:0] we,
                         input logic [19:0] sb, input logic [59:0] eb,
                         input int win);
      logic [9:0]  s;
      logic [29:0] b;
      logic [29:0] ea;
      logic [9:0]  sa;
      s = sb[win*10 +: 10];
      b = eb[win*30 +: 30];
      exp_prog = 0;
      rd_seq   = 0;
      sram_rds = 0;
      beats    = 0;
      max_out  = 0;
      for (int i = 0; i < LW; i++) begin
         ea = (b & ~30'(LW - 1)) | ((b + 30'(i)) & 30'(LW - 1));
         sa = (s & ~10'(LW - 1)) | ((s + 10'(i)) & 10'(LW - 1));
         if (we[win]) begin
            ext_q.push_back(ext_exp_t'{addr: ea, we: 1'b1,
                                       data: 32'hA000 + 32'(sa - 10'h3C0)});
         end else begin
            ext_q.push_back(ext_exp_t'{addr: ea, we: 1'b0, data: 32'h0});
            sw_q.push_back(sw_exp_t'{addr: sa, data: 32'(i)});
         end
      end
      @(posedge clk);
      #1;
      in_ce   = ce;
      in_we   = we;
      in_sram = sb;
      in_ext  = eb;
      @(posedge clk);
      #1;
      in_ce  = '0;
      active = 1'b1;
      @(negedge clk);
      check("cache_id", 64'(cid), 64'(win));
   endtask

   task automatic wait_done();
      for (int n = 0; n < 3000 && active; n++) @(negedge clk);
      check("timeout", 64'(active), 64'(0));
      repeat (4) @(negedge clk);
      check("ext_left", 64'(ext_q.size()), 64'(0));
      check("sram_left", 64'(sw_q.size()), 64'(0));
      check("ext_idle", 64'(ext_if.OUT_EXT_valid), 64'(0));
   endtask

   task automatic xfer(input logic [NC-1:0] ce, input logic [NC-1:0] we,
                       input logic [19:0] sb, input logic [59:0] eb,
                       input int win);
      launch(ce, we, sb, eb, win);
      wait_done();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      preload = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      preload = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_prog", 64'(prog), 64'(0));
      check("rst_cid", 64'(cid), 64'(0));
      check("rst_ext_valid", 64'(ext_if.OUT_EXT_valid), 64'(0));
      check("rst_ext_addr", 64'(ext_if.OUT_EXT_addr), 64'(0));
      check("rst_ext_data", 64'(ext_if.OUT_EXT_data), 64'(0));
      check("rst_cache_ce", 64'(c_ce), 64'(0));
      check("rst_cache_addr", 64'(c_addr), 64'(0));
      check("rst_stat", 64'(st_f | st_e | st_b), 64'(0));

      rdy_mode = 0;
      xfer(2'b01, 2'b00, {10'h0, 10'h140}, {30'h0, 30'h1040}, 0);

      rdy_mode = 1;
      xfer(2'b10, 2'b10, {10'h3C0, 10'h0}, {30'h2000, 30'h0}, 1);
      check("fifo_bound", 64'(max_out <= DEP), 64'(1));
      check("evict_beats", 64'(beats), 64'(LW));

      rdy_mode = 0;
      xfer(2'b11, 2'b00, {10'h200, 10'h000}, {30'h5000, 30'h3000}, 0);

      xfer(2'b01, 2'b00, {10'h0, 10'h17E}, {30'h0, 30'hFFE}, 0);

      rdy_mode = 2;
      launch(2'b01, 2'b01, {10'h0, 10'h3C0}, {30'h0, 30'h4000}, 0);
      for (int n = 0; n < 500 && beats < 10; n++) @(negedge clk);
      check("beats_10", 64'(beats >= 10), 64'(1));
      @(posedge clk);
      #1;
      mon_on = 1'b0;
      active = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ext_q.delete();
      sw_q.delete();
      resp_q.delete();
      @(negedge clk);
      check("mid_rst_busy", 64'(busy), 64'(0));
      check("mid_rst_valid", 64'(ext_if.OUT_EXT_valid), 64'(0));
      check("mid_rst_prog", 64'(prog), 64'(0));
      mon_on = 1'b1;

      rdy_mode = 0;
      xfer(2'b01, 2'b00, {10'h0, 10'h100}, {30'h0, 30'h6000}, 0);

`ifdef LINE_MEMORY_CONTROLLER_STATS_EN
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      exp_busy = 0;
      @(negedge clk);
      check("stat_clear", 64'(st_f | st_e | st_b), 64'(0));
      rdy_mode = 2;
      xfer(2'b01, 2'b00, {10'h0, 10'h040}, {30'h0, 30'h7000}, 0);
      xfer(2'b10, 2'b00, {10'h080, 10'h0}, {30'h7100, 30'h0}, 1);
      xfer(2'b01, 2'b01, {10'h0, 10'h3C0}, {30'h0, 30'h7200}, 0);
      check("stat_fills", 64'(st_f), 64'(2));
      check("stat_evicts", 64'(st_e), 64'(1));
      check("stat_busy", 64'(st_b), 64'(exp_busy));
`else
      check("stat_fills_off", 64'(st_f), 64'(0));
      check("stat_evicts_off", 64'(st_e), 64'(0));
      check("stat_busy_off", 64'(st_b), 64'(0));
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
